pll_dyn_cfg: RTL and testbench

Dynamic reconfiguration controller for the GW1N-1 rPLL. It drives the PLL's dynamic divider-select inputs and its RESET input, then waits for LOCK. A request/ready handshake from the I2C register file or a host accepts a new divider set. The block applies it with a safe reset sequence and reports done or timeout. It sits beside the PLL wrapper, runs on the PLL input clock, and is the sole driver of IDSEL/FBDSEL/ODSEL/RESET.

---
 rtl/pll_cfg_pkg.sv | 21 ++
 rtl/pll_lock_sync.sv | 24 ++
 rtl/pll_dyn_cfg.sv | 147 ++++++++++++++
 tb/tb_pll_dyn_cfg.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/pll_cfg_pkg.sv
// Shared types for the rPLL dynamic reconfiguration controller:
// sequencer states, select width and the divider-select encoding.
package pll_cfg_pkg;

    localparam int SEL_W = 6;

    typedef logic [SEL_W-1:0] sel_t;

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        RESET,
        WAIT_LOCK
    } state_e;

    // rPLL IDSEL/FBDSEL take the inverted raw divider value
    function automatic sel_t enc_div(input sel_t v);
        return ~v;
    endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchronizer bringing rPLL LOCK into the clk domain.
module pll_lock_sync (
    input  logic clk,
    input  logic rst,
    input  logic lock_i,
    output logic lock_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= lock_i;
            sync_q <= meta_q;
        end
    end

    assign lock_o = sync_q;

endmodule

// File: rtl/pll_dyn_cfg.sv
// rPLL dynamic divider reconfiguration: accept, settle, reset pulse, wait lock.
// Optional request range check enabled by PLL_CFG_RANGE_CHECK_EN.
module pll_dyn_cfg
    import pll_cfg_pkg::*;
#(
    parameter int         SETUP_CYCLES   = 4,
    parameter int         RESET_CYCLES   = 16,
    parameter int         LOCK_TIMEOUT   = 100000,
    parameter logic [5:0] DEF_IDIV       = 6'd0,
    parameter logic [5:0] DEF_FBDIV      = 6'd3,
    parameter logic [5:0] DEF_ODSEL      = 6'h3F,
    parameter int         FIN_MHZ        = 100,
    parameter int         CLKOUT_MAX_MHZ = 400,
    parameter int         PFD_MIN_MHZ    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [5:0] req_idiv,
    input  logic [5:0] req_fbdiv,
    input  logic [5:0] req_odsel,
    output logic [5:0] pll_idsel,
    output logic [5:0] pll_fbdsel,
    output logic [5:0] pll_odsel,
    output logic       pll_reset,
    input  logic       pll_lock,
    output logic       locked,
    output logic       cfg_done,
    output logic       cfg_err
);

    localparam int MAX_SR  = (SETUP_CYCLES > RESET_CYCLES) ?
                             SETUP_CYCLES : RESET_CYCLES;
    localparam int CNT_MAX = (MAX_SR > LOCK_TIMEOUT) ?
                             MAX_SR : LOCK_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    sel_t             idiv_q, fbdiv_q, odsel_q;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             accept;
    logic             range_ok;

    pll_lock_sync u_lock_sync (
        .clk    (clk),
        .rst    (rst),
        .lock_i (pll_lock),
        .lock_o (locked)
    );

`ifdef PLL_CFG_RANGE_CHECK_EN
    logic [15:0] idiv_r;
    logic [15:0] fbdiv_r;
    logic [15:0] pfd_min;
    logic [15:0] vco_out;
    logic [15:0] vco_max;

    always_comb begin
        idiv_r   = 16'(req_idiv) + 16'd1;
        fbdiv_r  = 16'(req_fbdiv) + 16'd1;
        pfd_min  = 16'(PFD_MIN_MHZ) * idiv_r;
        vco_out  = 16'(FIN_MHZ) * fbdiv_r;
        vco_max  = 16'(CLKOUT_MAX_MHZ) * idiv_r;
        range_ok = !(16'(FIN_MHZ) < pfd_min) && !(vco_out > vco_max);
    end
`else
    assign range_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idiv_q  <= DEF_IDIV;
            fbdiv_q <= DEF_FBDIV;
            odsel_q <= DEF_ODSEL;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            if (accept) begin
                idiv_q  <= req_idiv;
                fbdiv_q <= req_fbdiv;
                odsel_q <= req_odsel;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        accept  = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (req_valid) begin
                    if (range_ok) begin
                        accept  = 1'b1;
                        state_d = APPLY;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            APPLY: begin
                if (cnt_q == CNT_W'(SETUP_CYCLES - 1))
                    state_d = RESET;
            end
            RESET: begin
                if (cnt_q == CNT_W'(RESET_CYCLES - 1))
                    state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                // first two cycles still carry pre-reset lock through the sync
                if (locked && cnt_q >= CNT_W'(2)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d != state_q)
            cnt_d = '0;
    end

    always_comb begin
        req_ready  = (state_q == IDLE);
        pll_reset  = (state_q == RESET);
        pll_idsel  = enc_div(idiv_q);
        pll_fbdsel = enc_div(fbdiv_q);
        pll_odsel  = odsel_q;
        cfg_done   = done_q;
        cfg_err    = err_q;
    end

endmodule

// File: tb/tb_pll_dyn_cfg.sv
// Directed bench for pll_dyn_cfg: reset, lock, timeout, held request, mid-reset rst.
module tb_pll_dyn_cfg;

    localparam int LT = 200;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [5:0] req_idiv;
    logic [5:0] req_fbdiv;
    logic [5:0] req_odsel;
    logic [5:0] pll_idsel;
    logic [5:0] pll_fbdsel;
    logic [5:0] pll_odsel;
    logic       pll_reset;
    logic       pll_lock;
    logic       locked;
    logic       cfg_done;
    logic       cfg_err;

    int n_chk  = 0;
    int n_fail = 0;

    pll_dyn_cfg #(
        .SETUP_CYCLES (4),
        .RESET_CYCLES (16),
        .LOCK_TIMEOUT (LT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_idiv   (req_idiv),
        .req_fbdiv  (req_fbdiv),
        .req_odsel  (req_odsel),
        .pll_idsel  (pll_idsel),
        .pll_fbdsel (pll_fbdsel),
        .pll_odsel  (pll_odsel),
        .pll_reset  (pll_reset),
        .pll_lock   (pll_lock),
        .locked     (locked),
        .cfg_done   (cfg_done),
        .cfg_err    (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int first_hi, last_hi, hi_cnt, bad, dones, errs;
        int done_at, err_at, lock_at, rdy_at_done;

        rst = 1'b1;
        req_valid = 1'b0;
        req_idiv = '0;
        req_fbdiv = '0;
        req_odsel = '0;
        pll_lock = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        chk("rst_idsel", pll_idsel, 'h3F);
        chk("rst_fbdsel", pll_fbdsel, 'h3C);
        chk("rst_odsel", pll_odsel, 'h3F);
        chk("rst_ready", req_ready, 1);
        chk("rst_pllrst", pll_reset, 0);
        chk("rst_flags", {cfg_done, cfg_err, locked}, 0);

        // request idiv=1 fbdiv=7; lock 50 cycles after reset release
        req_valid = 1'b1;
        req_idiv = 6'd1;
        req_fbdiv = 6'd7;
        req_odsel = 6'h05;
        tick();
        req_valid = 1'b0;
        chk("t1_idsel", pll_idsel, 'h3E);
        chk("t1_fbdsel", pll_fbdsel, 'h38);
        chk("t1_odsel", pll_odsel, 'h05);
        chk("t1_ready", req_ready, 0);
        first_hi = -1; last_hi = -1; hi_cnt = 0; bad = 0;
        dones = 0; errs = 0; done_at = -1; lock_at = -1; rdy_at_done = -1;
        for (int n = 1; n <= 100; n++) begin
            if (n > 1) tick();
            if (n == 71) pll_lock = 1'b1;
            if (pll_reset) begin
                if (first_hi < 0) first_hi = n;
                last_hi = n;
                hi_cnt++;
                if ({pll_idsel, pll_fbdsel} != {6'h3E, 6'h38}) bad++;
            end
            if (locked && lock_at < 0) lock_at = n;
            if (cfg_done) begin
                dones++;
                done_at = n;
                rdy_at_done = int'(req_ready);
            end
            if (cfg_err) errs++;
        end
        chk("t1_rst_first", first_hi, 5);
        chk("t1_rst_last", last_hi, 20);
        chk("t1_rst_width", hi_cnt, 16);
        chk("t1_sel_stable", bad, 0);
        chk("t1_lock_at", lock_at, 73);
        chk("t1_done_at", done_at, 74);
        chk("t1_done_cnt", dones, 1);
        chk("t1_err_cnt", errs, 0);
        chk("t1_ready_done", rdy_at_done, 1);
        chk("t1_ready_end", req_ready, 1);

        // lock never comes; valid stays high with different payload
        pll_lock = 1'b0;
        tick();
        tick();
        tick();
        chk("t2_unlocked", locked, 0);
        req_valid = 1'b1;
        req_idiv = 6'd2;
        req_fbdiv = 6'd3;
        req_odsel = 6'h11;
        tick();
        req_idiv = 6'd5;
        req_fbdiv = 6'd1;
        req_odsel = 6'h22;
        hi_cnt = 0; bad = 0; errs = 0; dones = 0; err_at = -1;
        for (int n = 1; n <= 221; n++) begin
            if (n > 1) tick();
            if (pll_reset) hi_cnt++;
            if ({pll_idsel, pll_fbdsel, pll_odsel} !=
                {6'h3D, 6'h3C, 6'h11}) bad++;
            if (n > 1 && req_ready && n < 221) bad++;
            if (cfg_err) begin
                errs++;
                err_at = n;
            end
            if (cfg_done) dones++;
        end
        chk("t2_no_reaccept", bad, 0);
        chk("t2_rst_width", hi_cnt, 16);
        chk("t2_err_at", err_at, 21 + LT);
        chk("t2_err_cnt", errs, 1);
        chk("t2_done_cnt", dones, 0);
        chk("t2_ready_err", req_ready, 1);
        tick();
        req_valid = 1'b0;
        chk("t2_new_idsel", pll_idsel, 'h3A);
        chk("t2_new_fbdsel", pll_fbdsel, 'h3E);
        chk("t2_new_odsel", pll_odsel, 'h22);
        chk("t2_new_ready", req_ready, 0);
        chk("t2_err_pulse", cfg_err, 0);

        // rst in the middle of the reset pulse of that second accept
        for (int n = 2; n <= 9; n++) tick();
        chk("t3_in_reset", pll_reset, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t3_pllrst", pll_reset, 0);
        chk("t3_idsel", pll_idsel, 'h3F);
        chk("t3_fbdsel", pll_fbdsel, 'h3C);
        chk("t3_odsel", pll_odsel, 'h3F);
        chk("t3_ready", req_ready, 1);
        hi_cnt = 0; dones = 0; errs = 0;
        for (int n = 0; n < 300; n++) begin
            tick();
            if (pll_reset) hi_cnt++;
            if (cfg_done) dones++;
            if (cfg_err) errs++;
        end
        chk("t3_no_pllrst", hi_cnt, 0);
        chk("t3_no_done", dones, 0);
        chk("t3_no_err", errs, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
